// File: rtl/coord_display_ctrl.sv
// ---------------------------------------------------------------------------
// coord_display_ctrl
// Accepts binary X/Y/Z coordinate updates over valid/ready, converts each to
// 3-digit BCD with a serial double-dabble engine, stages the result in a
// per-channel shadow register and commits shadows to the displayed digits
// only on frame_start, so digits never change mid-frame.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-low reset
//   in_valid     update request
//   in_ready     controller can accept an update this cycle
//   in_ch        target channel (0=X, 1=Y, 2=Z, 3=invalid)
//   in_value     unsigned binary coordinate
//   frame_start  single-cycle pulse at start of vertical blank
//   x/y/z_bcd    displayed digits {hund, tens, ones}
//   commit       pulse: at least one channel was committed
//   err          pulse: an update with in_ch=3 was discarded
// ---------------------------------------------------------------------------
module coord_display_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ch,
    input  logic [DATA_W-1:0] in_value,
    input  logic              frame_start,
    output logic [11:0]       x_bcd,
    output logic [11:0]       y_bcd,
    output logic [11:0]       z_bcd,
    output logic              commit,
    output logic              err
);

    localparam int unsigned BCD_W  = 12;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned SR_W   = BCD_W + DATA_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_err;
    logic                r_commit;
    logic [1:0]          r_ch;
    logic [SR_W-1:0]     r_sr;
    logic [CNT_W-1:0]    r_count;
    logic [BCD_W-1:0]    r_shadow [NUM_CH];
    logic [BCD_W-1:0]    r_disp   [NUM_CH];
    logic [NUM_CH-1:0]   r_pending;

    logic [SR_W-1:0]     w_adj;
    logic [SR_W-1:0]     w_shift;
    logic [NUM_CH-1:0]   w_store_mask;
    logic                w_xfer;

    assign w_xfer = in_valid & r_ready;

    // Double-dabble add-3 correction on each BCD nibble, then shift left by one
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 3; i++) begin
            if (r_sr[DATA_W + 4*i +: 4] >= 4'd5)
                w_adj[DATA_W + 4*i +: 4] = r_sr[DATA_W + 4*i +: 4] + 4'd3;
        end
        w_shift = {w_adj[SR_W-2:0], 1'b0};
    end

    // Pending bit set by STORE; it overrides a coincident clear from frame_start
    always_comb begin
        w_store_mask = '0;
        if (r_state == S_STORE)
            w_store_mask = NUM_CH'(3'b001 << r_ch);
    end

    // Conversion FSM and shadow writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_ch      <= 2'd0;
            r_sr      <= '0;
            r_count   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (in_ch == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ch    <= in_ch;
                            r_sr    <= {BCD_W'(0), in_value};
                            r_count <= CNT_W'(DATA_W);
                            r_ready <= 1'b0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sr    <= w_shift;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1))
                        r_state <= S_STORE;
                end
                S_STORE: begin
                    // After DATA_W shifts the full BCD result sits in the top bits
                    case (r_ch)
                        2'd0:    r_shadow[0] <= r_sr[SR_W-1 -: BCD_W];
                        2'd1:    r_shadow[1] <= r_sr[SR_W-1 -: BCD_W];
                        default: r_shadow[2] <= r_sr[SR_W-1 -: BCD_W];
                    endcase
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame-synchronous commit of pending shadows to the displayed digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_commit  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_disp[i] <= '0;
        end else begin
            r_commit  <= frame_start & (|r_pending);
            r_pending <= (frame_start ? NUM_CH'(0) : r_pending) | w_store_mask;
            for (int i = 0; i < NUM_CH; i++) begin
                if (frame_start && r_pending[i])
                    r_disp[i] <= r_shadow[i];
            end
        end
    end

    assign in_ready = r_ready;
    assign err      = r_err;
    assign commit   = r_commit;
    assign x_bcd    = r_disp[0];
    assign y_bcd    = r_disp[1];
    assign z_bcd    = r_disp[2];

endmodule

// File: tb/tb_coord_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coord_display_ctrl
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level reference model (busy countdown + decimal digit math).
// ---------------------------------------------------------------------------
module tb_coord_display_ctrl;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_ch;
    logic [DATA_W-1:0] in_value;
    logic              frame_start;
    logic [11:0]       x_bcd;
    logic [11:0]       y_bcd;
    logic [11:0]       z_bcd;
    logic              commit;
    logic              err;

    int checks   = 0;
    int failures = 0;

    coord_display_ctrl #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .in_value    (in_value),
        .frame_start (frame_start),
        .x_bcd       (x_bcd),
        .y_bcd       (y_bcd),
        .z_bcd       (z_bcd),
        .commit      (commit),
        .err         (err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_busy;
    int          m_ch;
    int          m_val;
    logic [11:0] m_shadow [3];
    logic [11:0] m_disp   [3];
    bit          m_pend   [3];
    bit          m_commit;
    bit          m_err;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy   = 0;
            m_ch     = 0;
            m_val    = 0;
            m_commit = 0;
            m_err    = 0;
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] = '0;
                m_disp[i]   = '0;
                m_pend[i]   = 0;
            end
        end else begin
            bit any;
            any = 0;
            // commit sees shadows as they were before this edge
            if (frame_start) begin
                for (int i = 0; i < 3; i++) begin
                    if (m_pend[i]) begin
                        any       = 1;
                        m_disp[i] = m_shadow[i];
                        m_pend[i] = 0;
                    end
                end
            end
            m_commit = any;
            m_err    = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_shadow[m_ch] = to_bcd(m_val);
                    m_pend[m_ch]   = 1;
                end
            end else if (in_valid) begin
                if (in_ch == 2'd3) begin
                    m_err = 1;
                end else begin
                    m_busy = DATA_W + 1;
                    m_ch   = int'(in_ch);
                    m_val  = int'(in_value);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
        chk("x_bcd",    32'(x_bcd),    32'(m_disp[0]));
        chk("y_bcd",    32'(y_bcd),    32'(m_disp[1]));
        chk("z_bcd",    32'(z_bcd),    32'(m_disp[2]));
        chk("commit",   32'(commit),   32'(m_commit));
        chk("err",      32'(err),      32'(m_err));
    endtask

    // Check outputs on the falling edge, then drive inputs for the next rising edge
    task automatic step(input logic v, input logic [1:0] ch, input int val, input logic fs);
        @(negedge clk);
        check_outputs();
        in_valid    = v;
        in_ch       = ch;
        in_value    = DATA_W'(val);
        frame_start = fs;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_ch       = 2'd0;
        in_value    = '0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_x",     32'(x_bcd),    32'h000);
        rst = 1'b1;

        // frame_start with nothing pending
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("no_commit", 32'(commit), 32'd0);

        // ch0 = 7
        step(1'b1, 2'd0, 7, 1'b0);
        idle(10);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("x_007",  32'(x_bcd),  32'h007);
        chk("cm_007", 32'(commit), 32'd1);

        // back-to-back with in_valid held
        step(1'b1, 2'd1, 255, 1'b0);
        repeat (10) step(1'b1, 2'd2, 0, 1'b0);
        repeat (10) step(1'b1, 2'd0, 100, 1'b0);
        idle(10);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("y_255", 32'(y_bcd), 32'h255);
        chk("z_000", 32'(z_bcd), 32'h000);
        chk("x_100", 32'(x_bcd), 32'h100);

        // last write wins
        step(1'b1, 2'd2, 42, 1'b0);
        idle(10);
        step(1'b1, 2'd2, 43, 1'b0);
        idle(10);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("z_043", 32'(z_bcd), 32'h043);

        // STORE of ch0=9 coincident with frame_start
        step(1'b1, 2'd0, 9, 1'b0);
        idle(8);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("x_hold", 32'(x_bcd), 32'h100);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("x_009", 32'(x_bcd), 32'h009);

        // invalid channel
        step(1'b1, 2'd3, 5, 1'b0);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("err_pulse", 32'(err), 32'd1);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("err_nocommit", 32'(commit), 32'd0);

        // reset mid-conversion
        step(1'b1, 2'd0, 200, 1'b0);
        idle(4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();
        chk("mid_rst_x", 32'(x_bcd), 32'h000);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2'd0, 200, 1'b0);
        idle(10);
        step(1'b0, 2'd0, 0, 1'b1);
        step(1'b0, 2'd0, 0, 1'b0);
        chk("x_200", 32'(x_bcd), 32'h200);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 11) == 0));
        end
        idle(12);
        step(1'b0, 2'd0, 0, 1'b1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
